// File: rtl/decode_stage_p.sv
// decode_stage_p: MIPS-style instruction decode stage.
// Decodes control, reads the register file, resolves beq/bne/j early
// (compare after the MEM forward muxes), computes branch/jump targets,
// keeps saturating branch statistics and registers the ID/EX payload.
// Optional: define WB_BYPASS_EN to make a same-cycle writeback visible to
// the register read (write-through); otherwise it shows up next cycle.
// Register fields are 5 bits wide, so REG_NUM is expected to be <= 32.
module decode_stage_p #(
    parameter int WIDTH     = 32,
    parameter int REG_NUM   = 32,
    parameter int CNT_WIDTH = 16,
    localparam int AW       = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_decode,
    input  logic [WIDTH-1:0]     pc_decode,
    input  logic                 valid_decode,
    input  logic                 stall_decode,
    input  logic                 flush_execute,
    input  logic                 regwrite_wb,
    input  logic [AW-1:0]        regaddr_wb,
    input  logic [WIDTH-1:0]     result_wb,
    input  logic [WIDTH-1:0]     aluout_mem,
    input  logic                 forwardA_decode,
    input  logic                 forwardB_decode,
    output logic                 pcsrc_decode,
    output logic                 jump_decode,
    output logic [WIDTH-1:0]     pc_branch,
    output logic [WIDTH-1:0]     pc_jump,
    output logic                 flush_fetch,
    output logic                 ex_valid,
    output logic [4:0]           ex_ctrl,
    output logic [3:0]           ex_alucontrol,
    output logic [WIDTH-1:0]     ex_data1,
    output logic [WIDTH-1:0]     ex_data2,
    output logic [WIDTH-1:0]     ex_imm,
    output logic [3*AW-1:0]      ex_regaddr,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] taken_cnt
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // instruction fields
    logic [5:0]    opcode, funct;
    logic [4:0]    rs_f, rt_f, rd_f;
    logic [AW-1:0] rs, rt, rd;

    assign opcode = instr_decode[31:26];
    assign rs_f   = instr_decode[25:21];
    assign rt_f   = instr_decode[20:16];
    assign rd_f   = instr_decode[15:11];
    assign funct  = instr_decode[5:0];
    assign rs     = rs_f[AW-1:0];
    assign rt     = rt_f[AW-1:0];
    assign rd     = rd_f[AW-1:0];

    // ctrl = {regwrite, memtoreg, memwrite, alusrc, regdst}
    logic [4:0] ctrl;
    logic [3:0] alucontrol;
    logic       is_beq, is_bne, is_j;

    // main/ALU decoder; anything unrecognised collapses to a NOP
    always_comb begin
        ctrl       = 5'b00000;
        alucontrol = 4'b0000;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin ctrl = 5'b10001; alucontrol = ALU_ADD; end
                    6'b100010: begin ctrl = 5'b10001; alucontrol = ALU_SUB; end
                    6'b100100: begin ctrl = 5'b10001; alucontrol = ALU_AND; end
                    6'b100101: begin ctrl = 5'b10001; alucontrol = ALU_OR;  end
                    6'b101010: begin ctrl = 5'b10001; alucontrol = ALU_SLT; end
                    default:   ;
                endcase
            end
            6'b100011: begin ctrl = 5'b11010; alucontrol = ALU_ADD; end  // lw
            6'b101011: begin ctrl = 5'b00110; alucontrol = ALU_ADD; end  // sw
            6'b001000: begin ctrl = 5'b10010; alucontrol = ALU_ADD; end  // addi
            6'b000100: begin is_beq = 1'b1;   alucontrol = ALU_SUB; end
            6'b000101: begin is_bne = 1'b1;   alucontrol = ALU_SUB; end
            6'b000010: is_j = 1'b1;
            default:   ;
        endcase
    end

    // register file (entry 0 is never written and always reads as 0)
    logic [WIDTH-1:0] regs [REG_NUM];
    logic [WIDTH-1:0] rd1, rd2;

    // writeback port; whole file clears on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (regwrite_wb && regaddr_wb != '0) begin
            regs[regaddr_wb] <= result_wb;
        end
    end

    // read ports, with optional write-through of the writeback data
    always_comb begin
        rd1 = regs[rs];
        rd2 = regs[rt];
`ifdef WB_BYPASS_EN
        if (regwrite_wb && regaddr_wb != '0 && regaddr_wb == rs) rd1 = result_wb;
        if (regwrite_wb && regaddr_wb != '0 && regaddr_wb == rt) rd2 = result_wb;
`else
`endif
        if (rs == '0) rd1 = '0;
        if (rt == '0) rd2 = '0;
    end

    // early branch resolution and targets
    logic [WIDTH-1:0] imm_ext, cmp_a, cmp_b;
    logic             go, br_fire, taken;

    assign imm_ext      = {{(WIDTH-16){instr_decode[15]}}, instr_decode[15:0]};
    assign pc_branch    = pc_decode + (imm_ext << 2);
    assign pc_jump      = {pc_decode[WIDTH-1:28], instr_decode[25:0], 2'b00};
    assign cmp_a        = forwardA_decode ? aluout_mem : rd1;
    assign cmp_b        = forwardB_decode ? aluout_mem : rd2;
    assign taken        = is_beq ? (cmp_a == cmp_b) : (cmp_a != cmp_b);
    assign go           = valid_decode & ~stall_decode;
    assign br_fire      = (is_beq | is_bne) & go;
    assign pcsrc_decode = br_fire & taken;
    assign jump_decode  = is_j & go;
    assign flush_fetch  = pcsrc_decode | jump_decode;

    // ID/EX register: flush beats stall beats load; bubbles hold the data fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid      <= 1'b0;
            ex_ctrl       <= '0;
            ex_alucontrol <= '0;
            ex_data1      <= '0;
            ex_data2      <= '0;
            ex_imm        <= '0;
            ex_regaddr    <= '0;
        end else if (flush_execute || stall_decode) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid      <= valid_decode;
            ex_ctrl       <= ctrl;
            ex_alucontrol <= alucontrol;
            ex_data1      <= rd1;
            ex_data2      <= rd2;
            ex_imm        <= imm_ext;
            ex_regaddr    <= {rs, rt, rd};
        end
    end

    // saturating branch statistics; a flush in the same cycle still counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            if (br_fire && br_cnt != '1)         br_cnt    <= br_cnt + CNT_ONE;
            if (pcsrc_decode && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p (WIDTH=32, REG_NUM=32, CNT_WIDTH=4).
module tb_decode_stage_p;

    localparam int W = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr_decode;
    logic [W-1:0]  pc_decode;
    logic          valid_decode, stall_decode, flush_execute;
    logic          regwrite_wb;
    logic [AW-1:0] regaddr_wb;
    logic [W-1:0]  result_wb, aluout_mem;
    logic          forwardA_decode, forwardB_decode;
    logic          pcsrc_decode, jump_decode, flush_fetch, ex_valid;
    logic [W-1:0]  pc_branch, pc_jump, ex_data1, ex_data2, ex_imm;
    logic [4:0]    ex_ctrl;
    logic [3:0]    ex_alucontrol;
    logic [3*AW-1:0] ex_regaddr;
    logic [CW-1:0] br_cnt, taken_cnt;

    int total = 0;
    int bad   = 0;

    decode_stage_p #(.WIDTH(W), .REG_NUM(32), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .instr_decode(instr_decode), .pc_decode(pc_decode),
        .valid_decode(valid_decode), .stall_decode(stall_decode),
        .flush_execute(flush_execute), .regwrite_wb(regwrite_wb),
        .regaddr_wb(regaddr_wb), .result_wb(result_wb), .aluout_mem(aluout_mem),
        .forwardA_decode(forwardA_decode), .forwardB_decode(forwardB_decode),
        .pcsrc_decode(pcsrc_decode), .jump_decode(jump_decode),
        .pc_branch(pc_branch), .pc_jump(pc_jump), .flush_fetch(flush_fetch),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_alucontrol(ex_alucontrol),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
        .ex_regaddr(ex_regaddr), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        regwrite_wb = 1'b1; regaddr_wb = a; result_wb = d;
        tick();
        regwrite_wb = 1'b0;
    endtask

    // instruction / expected {ctrl, alu} table for the decoder sweep
    logic [31:0] dec_in  [8];
    logic [8:0]  dec_exp [8];

    initial begin
        rst = 1'b0;
        instr_decode = '0; pc_decode = '0; valid_decode = 1'b0;
        stall_decode = 1'b0; flush_execute = 1'b0;
        regwrite_wb = 1'b0; regaddr_wb = '0; result_wb = '0; aluout_mem = '0;
        forwardA_decode = 1'b0; forwardB_decode = 1'b0;

        // reset state
        #3;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_br_cnt", br_cnt, 0);
        chk("rst_taken_cnt", taken_cnt, 0);
        #9 rst = 1'b1;
        tick();

        // add r3,r5,r5 after writing r5
        wb(5'd5, 32'h0000_1234);
        instr_decode = r_op(5'd5, 5'd5, 5'd3, 6'b100000); valid_decode = 1'b1;
        tick();
        chk("add_alu", ex_alucontrol, 4'b0010);
        chk("add_data1", ex_data1, 32'h1234);
        chk("add_data2", ex_data2, 32'h1234);
        chk("add_ctrl", ex_ctrl, 5'b10001);
        chk("add_valid", ex_valid, 1);
        chk("add_regaddr", ex_regaddr, {5'd5, 5'd5, 5'd3});

        // beq r1,r2,+4 taken with r1=r2=7
        valid_decode = 1'b0;
        wb(5'd1, 32'd7);
        wb(5'd2, 32'd7);
        instr_decode = i_op(6'b000100, 5'd1, 5'd2, 16'd4); pc_decode = 32'h100; valid_decode = 1'b1;
        #2;
        chk("beq_pcsrc", pcsrc_decode, 1);
        chk("beq_target", pc_branch, 32'h110);
        chk("beq_flush_fetch", flush_fetch, 1);
        chk("beq_jump", jump_decode, 0);
        tick();
        chk("beq_br_cnt", br_cnt, 1);
        chk("beq_taken_cnt", taken_cnt, 1);
        chk("beq_ex_alu", ex_alucontrol, 4'b0110);
        chk("beq_ex_ctrl", ex_ctrl, 0);

        // bne r1,r2 with rs forwarded from MEM (9) and r2=9 -> not taken
        valid_decode = 1'b0;
        wb(5'd2, 32'd9);
        instr_decode = i_op(6'b000101, 5'd1, 5'd2, 16'd4); valid_decode = 1'b1;
        forwardA_decode = 1'b1; aluout_mem = 32'd9;
        #2;
        chk("bne_fwd_pcsrc", pcsrc_decode, 0);
        chk("bne_fwd_flush_fetch", flush_fetch, 0);
        tick();
        forwardA_decode = 1'b0;
        chk("bne_br_cnt", br_cnt, 2);
        chk("bne_taken_cnt", taken_cnt, 1);

        // stalled taken beq: no redirect, no count
        instr_decode = i_op(6'b000100, 5'd1, 5'd1, 16'd4); stall_decode = 1'b1;
        #2;
        chk("stall_beq_pcsrc", pcsrc_decode, 0);
        tick();
        chk("stall_beq_br_cnt", br_cnt, 2);

        // stalled lw r6,8(r5) then release
        instr_decode = i_op(6'b100011, 5'd5, 5'd6, 16'd8);
        tick();
        chk("stall_lw_valid", ex_valid, 0);
        chk("stall_lw_ctrl", ex_ctrl, 0);
        chk("stall_lw_taken_cnt", taken_cnt, 1);
        stall_decode = 1'b0;
        tick();
        chk("lw_ctrl", ex_ctrl, 5'b11010);
        chk("lw_valid", ex_valid, 1);
        chk("lw_imm", ex_imm, 32'd8);
        chk("lw_data1", ex_data1, 32'h1234);

        // flush_execute with a taken beq: redirect and count survive
        instr_decode = i_op(6'b000100, 5'd1, 5'd1, 16'd2); flush_execute = 1'b1;
        #2;
        chk("flush_beq_pcsrc", pcsrc_decode, 1);
        tick();
        flush_execute = 1'b0;
        chk("flush_beq_valid", ex_valid, 0);
        chk("flush_beq_ctrl", ex_ctrl, 0);
        chk("flush_beq_br_cnt", br_cnt, 3);
        chk("flush_beq_taken_cnt", taken_cnt, 2);

        // backward branch beq r0,r0,-1 from 0x100
        instr_decode = i_op(6'b000100, 5'd0, 5'd0, 16'hFFFF); pc_decode = 32'h100;
        #2;
        chk("neg_target", pc_branch, 32'hFC);
        tick();
        chk("neg_imm", ex_imm, 32'hFFFF_FFFF);
        chk("neg_taken_cnt", taken_cnt, 3);

        // jump keeps PC upper nibble
        instr_decode = {6'b000010, 26'h40}; pc_decode = 32'hF000_0004;
        #2;
        chk("j_jump", jump_decode, 1);
        chk("j_target", pc_jump, 32'hF000_0100);
        chk("j_flush_fetch", flush_fetch, 1);
        chk("j_pcsrc", pcsrc_decode, 0);
        instr_decode = {6'b000010, 26'h40}; valid_decode = 1'b0;
        #1;
        chk("j_invalid_jump", jump_decode, 0);
        tick();

        // same-cycle writeback to r4 while decoding add r7,r4,r0
        wb(5'd4, 32'h11);
        instr_decode = r_op(5'd4, 5'd0, 5'd7, 6'b100000); valid_decode = 1'b1;
        regwrite_wb = 1'b1; regaddr_wb = 5'd4; result_wb = 32'hAB;
        tick();
        regwrite_wb = 1'b0;
`ifdef WB_BYPASS_EN
        chk("wb_same_cycle", ex_data1, 32'hAB);
`else
        chk("wb_same_cycle", ex_data1, 32'h11);
`endif
        tick();
        chk("wb_next_cycle", ex_data1, 32'hAB);

        // writes to r0 are dropped, also while r0 is being read
        instr_decode = r_op(5'd0, 5'd0, 5'd7, 6'b100000);
        regwrite_wb = 1'b1; regaddr_wb = 5'd0; result_wb = 32'hDEAD;
        tick();
        regwrite_wb = 1'b0;
        chk("r0_same_cycle", ex_data1, 0);
        tick();
        chk("r0_next_cycle", ex_data1, 0);

        // decoder sweep
        dec_in[0] = r_op(5'd1, 5'd2, 5'd3, 6'b100010); dec_exp[0] = {5'b10001, 4'b0110};
        dec_in[1] = r_op(5'd1, 5'd2, 5'd3, 6'b100100); dec_exp[1] = {5'b10001, 4'b0000};
        dec_in[2] = r_op(5'd1, 5'd2, 5'd3, 6'b100101); dec_exp[2] = {5'b10001, 4'b0001};
        dec_in[3] = r_op(5'd1, 5'd2, 5'd3, 6'b101010); dec_exp[3] = {5'b10001, 4'b0111};
        dec_in[4] = i_op(6'b101011, 5'd1, 5'd2, 16'd4); dec_exp[4] = {5'b00110, 4'b0010};
        dec_in[5] = i_op(6'b001000, 5'd1, 5'd2, 16'd4); dec_exp[5] = {5'b10010, 4'b0010};
        dec_in[6] = r_op(5'd1, 5'd2, 5'd3, 6'b100111); dec_exp[6] = 9'd0;
        dec_in[7] = i_op(6'b111111, 5'd1, 5'd2, 16'd4); dec_exp[7] = 9'd0;
        for (int i = 0; i < 8; i++) begin
            instr_decode = dec_in[i];
            tick();
            chk($sformatf("dec_%0d", i), {ex_ctrl, ex_alucontrol}, dec_exp[i]);
        end

        // saturation with 4-bit counters: start br=4 taken=3
        instr_decode = i_op(6'b000100, 5'd0, 5'd0, 16'd1);
        for (int i = 0; i < 11; i++) tick();
        chk("sat_br_at_max", br_cnt, 4'hF);
        chk("sat_taken_below_max", taken_cnt, 4'hE);
        for (int i = 0; i < 9; i++) tick();
        chk("sat_br_hold", br_cnt, 4'hF);
        chk("sat_taken_hold", taken_cnt, 4'hF);

        // reset in the middle of a stall
        instr_decode = i_op(6'b100011, 5'd5, 5'd6, 16'd8); stall_decode = 1'b1;
        tick();
        #1 rst = 1'b0;
        #1;
        chk("midrst_br_cnt", br_cnt, 0);
        chk("midrst_taken_cnt", taken_cnt, 0);
        chk("midrst_ex_imm", ex_imm, 0);
        chk("midrst_ex_alu", ex_alucontrol, 0);
        chk("midrst_ex_regaddr", ex_regaddr, 0);
        chk("midrst_ex_valid", ex_valid, 0);
        #2 rst = 1'b1;
        stall_decode = 1'b0; valid_decode = 1'b0;
        tick();
        chk("midrst_discard", ex_valid, 0);
        instr_decode = r_op(5'd5, 5'd5, 5'd3, 6'b100000); valid_decode = 1'b1;
        tick();
        chk("midrst_regs_clear", ex_data1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
